pipe_controller: RTL and testbench

Generates the per-frame position of the single on-screen pipe for the Flappy Bird display pipeline and drives `PipePositionX`/`PipePositionY` straight into `color_mapper`. Once per video frame it scrolls the pipe left by a fixed step. When the pipe leaves the screen it respawns at the right edge with a pseudo-random gap height from an 8-bit LFSR. It also emits a one-cycle score pulse when the pipe's trailing edge passes the bird column.

---
 rtl/pipe_controller.sv | 148 ++++++++++++++
 tb/tb_pipe_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// pipe_controller
// Scrolls the single on-screen pipe left once per video frame, respawns it at
// the right edge with an LFSR-derived gap height, and pulses pipe_passed when
// the pipe's trailing edge crosses the bird column.
// Optional build macro: PIPE_LFSR_FREERUN_EN (LFSR advances every Clk cycle).
module pipe_controller #(
    parameter int START_X = 640,
    parameter int Y_INIT  = 120,
    parameter int Y_MIN   = 40,
    parameter int SPEED   = 2,
    parameter int PIPE_W  = 90,
    parameter int BIRD_X  = 160
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       run,
    input  logic       freeze,
    output logic [9:0] PipePositionX,
    output logic [9:0] PipePositionY,
    output logic       pipe_passed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [9:0]  START_X_V = 10'(START_X);
    localparam logic [9:0]  Y_INIT_V  = 10'(Y_INIT);
    localparam logic [9:0]  Y_MIN_V   = 10'(Y_MIN);
    localparam logic [9:0]  SPEED_V   = 10'(SPEED);
    localparam logic [10:0] PIPE_W_V  = 11'(PIPE_W);
    localparam logic [10:0] BIRD_X_V  = 11'(BIRD_X);
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    state_t      state;
    logic        sync1, sync2, sync_prev;
    logic        tick;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_next;
    logic        respawn;
    logic [9:0]  x_next;
    logic [10:0] old_edge;
    logic [10:0] new_edge;
    logic        crossing;
    logic        respawn_step;

    // Two-stage synchronizer plus edge register for the asynchronous frame clock
    always_ff @(posedge Clk) begin
        // NOTE: all three flops reset to 1 so a frame_clk already high at
        // reset release looks like "no edge" rather than a spurious tick.
        if (Reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= frame_clk;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign tick = sync2 & ~sync_prev;

    // Position arithmetic: respawn test uses the pre-subtract X so X never wraps
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        respawn   = (PipePositionX < SPEED_V);
        x_next    = PipePositionX - SPEED_V;
        old_edge  = {1'b0, PipePositionX} + PIPE_W_V;
        new_edge  = {1'b0, x_next} + PIPE_W_V;
        crossing  = (old_edge >= BIRD_X_V) && (new_edge < BIRD_X_V);
        respawn_step = (state == SCROLL) && run && !freeze && tick && respawn;
    end

`ifdef PIPE_LFSR_FREERUN_EN
    // Free-running LFSR: respawn height depends on player timing
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end
`else
    // LFSR advances only on respawn, giving a deterministic height sequence
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else if (respawn_step) begin
            lfsr <= lfsr_next;
        end
    end
`endif

    // Control FSM with registered positions and score pulse
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in this block sees the pre-edge values of the others.
        if (Reset) begin
            state         <= IDLE;
            PipePositionX <= START_X_V;
            PipePositionY <= Y_INIT_V;
            pipe_passed   <= 1'b0;
        end else begin
            pipe_passed <= 1'b0;
            case (state)
                IDLE: begin
                    PipePositionX <= START_X_V;
                    PipePositionY <= Y_INIT_V;
                    if (run) begin
                        state <= SCROLL;
                    end
                end
                SCROLL: begin
                    if (!run) begin
                        state         <= IDLE;
                        PipePositionX <= START_X_V;
                        PipePositionY <= Y_INIT_V;
                    end else if (freeze) begin
                        state <= HOLD;
                    end else if (tick) begin
                        if (respawn) begin
                            PipePositionX <= START_X_V;
                            PipePositionY <= Y_MIN_V + {2'b00, lfsr};
                        end else begin
                            PipePositionX <= x_next;
                            pipe_passed   <= crossing;
                        end
                    end
                end
                HOLD: begin
                    if (!run) begin
                        state         <= IDLE;
                        PipePositionX <= START_X_V;
                        PipePositionY <= Y_INIT_V;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_controller.sv
// Directed testbench for pipe_controller (default build, deterministic LFSR).
// Inputs are driven and outputs sampled on the falling edge of Clk.
module tb_pipe_controller;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       run;
    logic       freeze;
    logic [9:0] PipePositionX;
    logic [9:0] PipePositionY;
    logic       pipe_passed;

    int tests;
    int fails;
    int pulses;
    int last_pulse_tick;
    int tick_no;

    pipe_controller dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .run          (run),
        .freeze       (freeze),
        .PipePositionX(PipePositionX),
        .PipePositionY(PipePositionY),
        .pipe_passed  (pipe_passed)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Record any score pulse seen at this sample point
    task automatic sample_pulse();
        if (pipe_passed === 1'b1) begin
            pulses++;
            last_pulse_tick = tick_no;
        end
    endtask

    // One frame: frame_clk high for 3 cycles, low for 2. The resulting tick is
    // live in the cycle after the 2nd falling edge; positions update before
    // the 3rd falling edge. freeze_at_tick raises freeze in the tick cycle.
    task automatic do_tick(input logic freeze_at_tick);
        frame_clk = 1'b1;
        tick_no++;
        @(negedge Clk); sample_pulse();
        @(negedge Clk); sample_pulse();
        if (freeze_at_tick) freeze = 1'b1;
        @(negedge Clk); sample_pulse();
        frame_clk = 1'b0;
        @(negedge Clk); sample_pulse();
        @(negedge Clk); sample_pulse();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pulses = 0;
        last_pulse_tick = 0;
        tick_no = 0;

        // Reset with frame_clk held high
        Reset = 1'b1;
        frame_clk = 1'b1;
        run = 1'b0;
        freeze = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_x", 32'(PipePositionX), 640);
        check("reset_y", 32'(PipePositionY), 120);
        check("reset_pp", 32'(pipe_passed), 0);

        // Release with run high: a spurious tick would move X
        Reset = 1'b0;
        run = 1'b1;
        repeat (10) @(negedge Clk);
        check("no_spurious_tick_x", 32'(PipePositionX), 640);
        check("no_spurious_tick_y", 32'(PipePositionY), 120);

        // First tick with latency check
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b1;
        tick_no = 1;
        repeat (2) @(negedge Clk);
        check("pre_update_x", 32'(PipePositionX), 640);
        @(negedge Clk);
        check("tick1_x", 32'(PipePositionX), 638);
        check("tick1_y", 32'(PipePositionY), 120);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);

        // Ticks 2..320 bring X to 0; the single pulse is at tick 286 (70->68)
        for (int i = 2; i <= 320; i++) do_tick(1'b0);
        check("tick320_x", 32'(PipePositionX), 0);
        check("pulse_count_1", 32'(pulses), 1);
        check("pulse_tick_1", 32'(last_pulse_tick), 286);

        // Tick 321: respawn with Y = 40 + 0xA5, no score pulse
        do_tick(1'b0);
        check("respawn1_x", 32'(PipePositionX), 640);
        check("respawn1_y", 32'(PipePositionY), 205);
        check("respawn1_no_pulse", 32'(pulses), 1);

        // Ticks 322..641 reach X=0 again; tick 642 respawns with 40 + 0x4A
        for (int i = 322; i <= 641; i++) do_tick(1'b0);
        check("tick641_x", 32'(PipePositionX), 0);
        check("tick641_y", 32'(PipePositionY), 205);
        do_tick(1'b0);
        check("respawn2_x", 32'(PipePositionX), 640);
        check("respawn2_y", 32'(PipePositionY), 114);
        check("pulse_count_2", 32'(pulses), 2);
        check("pulse_tick_2", 32'(last_pulse_tick), 607);

        // Move to X=600, then freeze coincident with a tick
        for (int i = 0; i < 20; i++) do_tick(1'b0);
        check("pre_freeze_x", 32'(PipePositionX), 600);
        do_tick(1'b1);
        check("freeze_drop_tick_x", 32'(PipePositionX), 600);
        for (int i = 0; i < 5; i++) do_tick(1'b0);
        check("hold_5_ticks_x", 32'(PipePositionX), 600);
        freeze = 1'b0;
        @(negedge Clk);
        do_tick(1'b0);
        check("unfreeze_no_resume_x", 32'(PipePositionX), 600);
        run = 1'b0;
        repeat (2) @(negedge Clk);
        check("run_drop_x", 32'(PipePositionX), 640);
        check("run_drop_y", 32'(PipePositionY), 120);

        // Scroll to X=400 and reset mid-SCROLL
        run = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 120; i++) do_tick(1'b0);
        check("pre_reset_x", 32'(PipePositionX), 400);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midreset_x", 32'(PipePositionX), 640);
        check("midreset_y", 32'(PipePositionY), 120);
        check("midreset_pp", 32'(pipe_passed), 0);

        // LFSR was reseeded: the next respawn height is again 205
        @(negedge Clk);
        for (int i = 0; i < 321; i++) do_tick(1'b0);
        check("post_reset_respawn_x", 32'(PipePositionX), 640);
        check("post_reset_respawn_y", 32'(PipePositionY), 205);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
